// File: rtl/ser_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
// State GAP exists only when SER_FRAME_TX_GAP_EN is defined.
package ser_frame_pkg;

  localparam int unsigned PORT_W    = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned GAP_TICKS = 2;

  localparam logic START_BIT = 1'b0;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    CNT,
    DATA,
`ifdef SER_FRAME_TX_GAP_EN
    GAP,
`endif
    FINISH
  } ser_tx_state_t;

endpackage

// File: rtl/ser_bit_cnt.sv
// Loadable down-counter stepping on the bit-rate tick; holds at zero.
module ser_bit_cnt
  import ser_frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  assign tc_c = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clk_en && !tc_c) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ser_frame_tx.sv
// Serial frame generator: start bit, port (MSB first), count (MSB first), payload (LSB first).
// Optional SER_FRAME_TX_GAP_EN inserts an idle gap before the frame completes.
module ser_frame_tx
  import ser_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clkEn,
  input  logic               start,
  input  logic [PORT_W-1:0]  port,
  input  logic [CNT_W-1:0]   count,
  input  logic [MAX_LEN-1:0] data,
  output logic               serOut,
  output logic               busy,
  output logic               done
);

  ser_tx_state_t      state_q, state_d;
  logic               ser_q, ser_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PORT_W-1:0]  port_q, port_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [MAX_LEN-1:0] shreg_q, shreg_d;

  logic               load_c;
  logic [CNT_W-1:0]   load_val_c;
  logic [CNT_W-1:0]   bit_cnt;
  logic               tc_c;
  logic               tail_c;

  // One counter serves every multi-tick phase; it is reloaded on each phase entry.
  ser_bit_cnt u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .clk_en   (clkEn),
    .load     (load_c),
    .load_val (load_val_c),
    .cnt      (bit_cnt),
    .tc_c     (tc_c)
  );

  always_comb begin
    state_d    = state_q;
    ser_d      = ser_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    port_d     = port_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    load_c     = 1'b0;
    load_val_c = '0;
    tail_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          port_d  = port;
          count_d = count;
          shreg_d = data;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (clkEn) begin
          ser_d      = START_BIT;
          load_c     = 1'b1;
          load_val_c = CNT_W'(PORT_W - 1);
          state_d    = PORT;
        end
      end
      PORT: begin
        if (clkEn) begin
          ser_d = 1'(port_q >> bit_cnt);
          if (tc_c) begin
            load_c     = 1'b1;
            load_val_c = CNT_W'(CNT_W - 1);
            state_d    = CNT;
          end
        end
      end
      CNT: begin
        if (clkEn) begin
          ser_d = 1'(count_q >> bit_cnt);
          if (tc_c) begin
            if (count_q != '0) begin
              load_c     = 1'b1;
              load_val_c = count_q - CNT_W'(1);
              state_d    = DATA;
            end else begin
              tail_c = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (clkEn) begin
          ser_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          tail_c  = tc_c;
        end
      end
`ifdef SER_FRAME_TX_GAP_EN
      GAP: begin
        if (clkEn) begin
          ser_d = IDLE_LVL;
          if (tc_c) state_d = FINISH;
        end
      end
`endif
      FINISH: begin
        if (clkEn) begin
          ser_d   = IDLE_LVL;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving the last payload/count bit: optional gap, then the idle-return tick.
    if (tail_c) begin
`ifdef SER_FRAME_TX_GAP_EN
      load_c     = 1'b1;
      load_val_c = CNT_W'(GAP_TICKS - 1);
      state_d    = GAP;
`else
      state_d    = FINISH;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ser_q   <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      port_q  <= '0;
      count_q <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      port_q  <= port_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
    end
  end

  assign serOut = ser_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Randomized bench for ser_frame_tx: expected frames are queued at issue time and
// checked by an independent line monitor at each frame end.
module tb_ser_frame_tx;

`ifdef SER_FRAME_TX_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  typedef struct {
    logic [31:0] bits;
    int          len;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clkEn;
  logic        start;
  logic [1:0]  port;
  logic [3:0]  count;
  logic [14:0] data;
  logic        serOut;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;
  int ce_mode;
  int unsigned cyc_cnt;
  exp_t exp_q[$];

  ser_frame_tx #(.MAX_LEN(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .clkEn  (clkEn),
    .start  (start),
    .port   (port),
    .count  (count),
    .data   (data),
    .serOut (serOut),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-rate tick: 0 = always high, 1 = every 4th cycle, 2 = random.
  always @(posedge clk) begin
    #1;
    cyc_cnt++;
    case (ce_mode)
      0:       clkEn = 1'b1;
      1:       clkEn = (cyc_cnt % 4 == 0);
      default: clkEn = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic void check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Frame as seen on the line, one entry per tick, from the framing rules.
  function automatic exp_t build(input logic [1:0] p, input logic [3:0] c, input logic [14:0] d);
    exp_t e;
    int   k;
    e.bits    = '0;
    e.bits[0] = 1'b0;
    e.bits[1] = p[1];
    e.bits[2] = p[0];
    for (int i = 0; i < 4; i++) e.bits[5'(3 + i)] = c[2'(3 - i)];
    k = 7;
    for (int i = 0; i < int'(c); i++) begin
      e.bits[5'(k)] = d[4'(i)];
      k++;
    end
    for (int g = 0; g < GAP; g++) begin
      e.bits[5'(k)] = 1'b1;
      k++;
    end
    e.bits[5'(k)] = 1'b1;
    e.len = k + 1;
    e.cyc = 8 + int'(c) + GAP;
    return e;
  endfunction

  // Line monitor
  logic        prev_ce;
  logic        last_ser;
  bit          in_frame;
  int          nbits;
  int          fcyc;
  logic [31:0] got_bits;

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
      prev_ce  = 1'b0;
      last_ser = 1'b1;
    end else begin
      if (in_frame) begin
        fcyc++;
        if (prev_ce) begin
          if (nbits < 32) got_bits[5'(nbits)] = serOut;
          nbits++;
        end else begin
          check("bit_hold", int'(serOut), int'(last_ser));
        end
        if (!done) check("busy_in_frame", int'(busy), 1);
      end else if (!busy) begin
        check("idle_level", int'(serOut), 1);
      end
      if (done) begin
        check("done_in_frame", int'(in_frame), 1);
        check("busy_at_done", int'(busy), 0);
        if (in_frame) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %0d bits, expected none", nbits);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("frame_len", nbits, e.len);
            check("frame_bits", int'(got_bits), int'(e.bits));
            if (e.cyc >= 0) check("busy_cycles", fcyc, e.cyc);
          end
        end
        in_frame = 1'b0;
      end else if (!in_frame && busy) begin
        in_frame = 1'b1;
        nbits    = 0;
        fcyc     = 0;
        got_bits = '0;
      end
      last_ser = serOut;
      prev_ce  = clkEn;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: still busy=%0b with %0d frames outstanding, expected idle", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: done=%0b, expected a pulse", done);
    end
  endtask

  task automatic send(input logic [1:0] p, input logic [3:0] c, input logic [14:0] d, input int mode);
    exp_t e;
    wait_idle();
    ce_mode = mode;
    @(posedge clk);
    #1;
    e = build(p, c, d);
    if (mode != 0) e.cyc = -1;
    exp_q.push_back(e);
    port  = p;
    count = c;
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    port  = 2'($urandom);
    count = 4'($urandom);
    data  = 15'($urandom);
    check("accept_busy", int'(busy), 1);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    ce_mode = 0;
    cyc_cnt = 0;
    rst     = 1'b0;
    clkEn   = 1'b0;
    start   = 1'b0;
    port    = '0;
    count   = '0;
    data    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_serOut", int'(serOut), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;

    // Directed frames
    send(2'd2, 4'd3, 15'b101, 0);
    send(2'd3, 4'd0, 15'h7FFF, 0);
    send(2'd0, 4'd15, 15'h5555, 1);
    send(2'd1, 4'd1, 15'h0001, 0);

    // start while busy with other inputs is ignored
    send(2'd1, 4'd10, 15'h2A5C, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      port  = 2'd2;
      count = 4'd2;
      data  = '1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;

    // start held through frame end: accepted the cycle after done
    wait_idle();
    ce_mode = 2;
    @(posedge clk);
    #1;
    port  = 2'd3;
    count = 4'd5;
    data  = 15'h0013;
    begin
      exp_t e;
      e = build(2'd3, 4'd5, 15'h0013);
      e.cyc = -1;
      exp_q.push_back(e);
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first_accept", int'(busy), 1);
    wait_done();
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second_accept", int'(busy), 1);

    // Reset during the payload
    send(2'd1, 4'd15, 15'($urandom), 0);
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("abort_serOut", int'(serOut), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    send(2'd2, 4'd6, 15'h002D, 0);

    // Random frames
    for (int i = 0; i < 14; i++) begin
      send(2'($urandom), 4'($urandom), 15'($urandom), int'($urandom_range(0, 2)));
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
